// File: rtl/bit_sweep_pkg.sv
// Shared types for the bit sweep encoder: the two-state sweep FSM encoding.
package bit_sweep_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_e;

endpackage

// File: rtl/sweep_pick.sv
// Combinational picker: selects the highest or lowest set bit of a vector and
// reports its index, its one-hot form and whether it is the only bit left.
module sweep_pick #(
    parameter int WIDTH = 16,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] vec_i,
    input  logic             msb_first_i,
    output logic [WIDTH-1:0] onehot_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             single_o
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    // The last match visited wins, so scan towards the bit we want to keep.
    always_comb begin
        idx_o = '0;
        if (msb_first_i) begin
            for (int i = 0; i < WIDTH; i++)
                if (vec_i[i]) idx_o = IDX_W'(i);
        end else begin
            for (int i = WIDTH - 1; i >= 0; i--)
                if (vec_i[i]) idx_o = IDX_W'(i);
        end
    end

    assign onehot_o = (vec_i == '0) ? '0 : (ONE << idx_o);
    assign single_o = (vec_i != '0) && ((vec_i & (vec_i - ONE)) == '0);

endmodule

// File: rtl/bit_sweep_encoder.sv
// Accepts a word and emits one handshaked beat per set bit, in MSB-first or
// LSB-first order; an all-zero word produces a single flagged empty beat.
import bit_sweep_pkg::*;

module bit_sweep_encoder #(
    parameter int WIDTH = 16,
    localparam int IDX_W = $clog2(WIDTH)
) (
    input  logic             clk_i,
    input  logic             arst_n_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             msb_first_i,
    input  logic             data_val_i,
    output logic             data_rdy_o,
    output logic [IDX_W-1:0] idx_o,
    output logic [WIDTH-1:0] onehot_o,
    output logic [IDX_W:0]   popcnt_o,
    output logic             last_o,
    output logic             empty_o,
    output logic             beat_val_o,
    input  logic             beat_rdy_i
);

    function automatic logic [IDX_W:0] popcount(input logic [WIDTH-1:0] v);
        logic [IDX_W:0] cnt;
        cnt = '0;
        for (int i = 0; i < WIDTH; i++) cnt = cnt + {{IDX_W{1'b0}}, v[i]};
        return cnt;
    endfunction

    state_e           state_q, state_d;
    logic [WIDTH-1:0] residue_q, residue_d;
    logic             msb_q, msb_d;
    logic [IDX_W:0]   popcnt_q, popcnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] onehot_q, onehot_d;
    logic             last_q, last_d;
    logic             empty_q, empty_d;
    logic             beat_val_q, beat_val_d;

    logic [WIDTH-1:0] pick_vec;
    logic             pick_msb;
    logic [WIDTH-1:0] pick_onehot;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_single;

    // In IDLE the picker looks at the incoming word so the first beat is ready
    // one cycle after accept; in SWEEP it looks at the residue minus the
    // bit currently on the outputs.
    always_comb begin
        pick_vec = residue_q & ~onehot_q;
        pick_msb = msb_q;
        if (state_q == IDLE) begin
            pick_vec = data_i;
            pick_msb = msb_first_i;
        end
    end

    sweep_pick #(.WIDTH(WIDTH), .IDX_W(IDX_W)) u_pick (
        .vec_i       (pick_vec),
        .msb_first_i (pick_msb),
        .onehot_o    (pick_onehot),
        .idx_o       (pick_idx),
        .single_o    (pick_single)
    );

    always_comb begin
        state_d    = state_q;
        residue_d  = residue_q;
        msb_d      = msb_q;
        popcnt_d   = popcnt_q;
        idx_d      = idx_q;
        onehot_d   = onehot_q;
        last_d     = last_q;
        empty_d    = empty_q;
        beat_val_d = beat_val_q;
        unique case (state_q)
            IDLE: begin
                if (data_val_i) begin
                    state_d    = SWEEP;
                    residue_d  = data_i;
                    msb_d      = msb_first_i;
                    popcnt_d   = popcount(data_i);
                    idx_d      = pick_idx;
                    onehot_d   = pick_onehot;
                    empty_d    = (data_i == '0);
                    last_d     = pick_single || (data_i == '0);
                    beat_val_d = 1'b1;
                end
            end
            SWEEP: begin
                if (beat_rdy_i) begin
                    if (last_q) begin
                        state_d    = IDLE;
                        residue_d  = '0;
                        popcnt_d   = '0;
                        idx_d      = '0;
                        onehot_d   = '0;
                        last_d     = 1'b0;
                        empty_d    = 1'b0;
                        beat_val_d = 1'b0;
                    end else begin
                        residue_d = pick_vec;
                        idx_d     = pick_idx;
                        onehot_d  = pick_onehot;
                        last_d    = pick_single;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q    <= IDLE;
            residue_q  <= '0;
            msb_q      <= 1'b0;
            popcnt_q   <= '0;
            idx_q      <= '0;
            onehot_q   <= '0;
            last_q     <= 1'b0;
            empty_q    <= 1'b0;
            beat_val_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            residue_q  <= residue_d;
            msb_q      <= msb_d;
            popcnt_q   <= popcnt_d;
            idx_q      <= idx_d;
            onehot_q   <= onehot_d;
            last_q     <= last_d;
            empty_q    <= empty_d;
            beat_val_q <= beat_val_d;
        end
    end

    assign data_rdy_o = (state_q == IDLE);
    assign idx_o      = idx_q;
    assign onehot_o   = onehot_q;
    assign popcnt_o   = popcnt_q;
    assign last_o     = last_q;
    assign empty_o    = empty_q;
    assign beat_val_o = beat_val_q;

endmodule
